tbird_button_conditioner: RTL

Front-end stage that sits directly upstream of `tbird`. It synchronises and debounces the three raw active-low turn/hazard buttons, arbitrates them into one registered, one-hot, active-high mode request, and generates the slow `step_tick` enable that paces the tail-light sequence. `tbird` consumes the clean requests and the tick instead of raw pins.

---
 rtl/tbird_pkg.sv | 23 ++
 rtl/tbird_button_conditioner_debounce.sv | 49 ++++
 rtl/tbird_button_conditioner.sv | 107 ++++++++++
 3 files changed

// File: rtl/tbird_pkg.sv
// Shared types and default timing constants for the tbird tail-light front end.
package tbird_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_RIGHT  = 2'd1,
    MODE_LEFT   = 2'd2,
    MODE_HAZARD = 2'd3
  } tbird_mode_t;

  localparam int TBIRD_DEBOUNCE_CYCLES = 1_000_000;
  localparam int TBIRD_TICK_DIV        = 12_500_000;

  // Hazard wins, and left+right together is also treated as hazard.
  function automatic tbird_mode_t level_mode(input logic hazard, input logic left,
                                             input logic right);
    if (hazard || (left && right)) return MODE_HAZARD;
    if (left)                      return MODE_LEFT;
    if (right)                     return MODE_RIGHT;
    return MODE_IDLE;
  endfunction

endpackage

// File: rtl/tbird_button_conditioner_debounce.sv
// button_debounce: two-flop synchroniser plus stable-count debouncer for one
// active-low button; reports the debounced pressed level and a press pulse.
module button_debounce
  import tbird_pkg::*;
#(
  parameter int CYCLES = TBIRD_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic pressed,
  output logic press
);

  localparam int W = $clog2(CYCLES);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic         meta;
  logic         synced;
  logic         stable;
  logic [W-1:0] count;

  // The count only survives while the synced level keeps disagreeing with stable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta   <= 1'b1;
      synced <= 1'b1;
      stable <= 1'b1;
      count  <= '0;
      press  <= 1'b0;
    end else begin
      meta   <= raw;
      synced <= meta;
      press  <= 1'b0;
      if (synced == stable) begin
        count <= '0;
      end else if (count == LAST) begin
        stable <= synced;
        count  <= '0;
        press  <= ~synced;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign pressed = ~stable;

endmodule

// File: rtl/tbird_button_conditioner.sv
// Debounces the three tbird buttons, arbitrates them into a one-hot mode request
// and paces the sequence with step_tick. Define TBIRD_COND_LATCH_EN for toggle mode.
module tbird_button_conditioner
  import tbird_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = TBIRD_DEBOUNCE_CYCLES,
  parameter int TICK_DIV        = TBIRD_TICK_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic right_button,
  input  logic left_button,
  input  logic hazard_button,
  output logic right_req,
  output logic left_req,
  output logic hazard_req,
  output logic step_tick,
  output logic mode_change
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [2:0]    pressed;
  logic [2:0]    press;
  tbird_mode_t   mode;
  tbird_mode_t   next_mode;
  logic [TW-1:0] prescale;

  button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clock(clock), .reset(reset), .raw(right_button),
    .pressed(pressed[0]), .press(press[0])
  );

  button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clock(clock), .reset(reset), .raw(left_button),
    .pressed(pressed[1]), .press(press[1])
  );

  button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_hazard (
    .clock(clock), .reset(reset), .raw(hazard_button),
    .pressed(pressed[2]), .press(press[2])
  );

`ifdef TBIRD_COND_LATCH_EN
  logic unused_pressed;
  assign unused_pressed = ^pressed;

  // Each debounced press toggles; simultaneous left+right acts like hazard.
  always_comb begin
    next_mode = mode;
    if (press[2] || (press[1] && press[0])) begin
      next_mode = (mode == MODE_HAZARD) ? MODE_IDLE : MODE_HAZARD;
    end else if (press[1]) begin
      case (mode)
        MODE_IDLE, MODE_RIGHT: next_mode = MODE_LEFT;
        MODE_LEFT:             next_mode = MODE_IDLE;
        default:               next_mode = mode;
      endcase
    end else if (press[0]) begin
      case (mode)
        MODE_IDLE, MODE_LEFT: next_mode = MODE_RIGHT;
        MODE_RIGHT:           next_mode = MODE_IDLE;
        default:              next_mode = mode;
      endcase
    end
  end
`else
  logic unused_press;
  assign unused_press = ^press;

  always_comb begin
    next_mode = level_mode(pressed[2], pressed[1], pressed[0]);
  end
`endif

  // Requests, mode_change and the prescaler all move on the same edge as mode,
  // so the first tick lands exactly TICK_DIV cycles after mode_change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode        <= MODE_IDLE;
      right_req   <= 1'b0;
      left_req    <= 1'b0;
      hazard_req  <= 1'b0;
      mode_change <= 1'b0;
      prescale    <= '0;
      step_tick   <= 1'b0;
    end else begin
      mode        <= next_mode;
      right_req   <= (next_mode == MODE_RIGHT);
      left_req    <= (next_mode == MODE_LEFT);
      hazard_req  <= (next_mode == MODE_HAZARD);
      mode_change <= (next_mode != mode);
      if ((next_mode != mode) || (next_mode == MODE_IDLE)) begin
        prescale  <= '0;
        step_tick <= 1'b0;
      end else if (prescale == TICK_LAST) begin
        prescale  <= '0;
        step_tick <= 1'b1;
      end else begin
        prescale  <= prescale + 1'b1;
        step_tick <= 1'b0;
      end
    end
  end

endmodule
